// File: rtl/counter_cmd_seq.sv
// Command-driven initiator for an up/down/preload counter, with a shadow model that checks the returned count.
// Optional build macro CTR_SEQ_RESYNC_EN: on a check mismatch, the shadow model resyncs to the observed count.
module counter_cmd_seq #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 8,
  localparam int ARG_W = (WIDTH > STEP_W) ? WIDTH : STEP_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [ARG_W-1:0] cmd_arg,
  output logic             ctr_enable,
  output logic             ctr_up_down,
  output logic             ctr_preload,
  output logic [WIDTH-1:0] ctr_data,
  input  logic [WIDTH-1:0] ctr_count,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] expected,
  output logic             mismatch,
  input  logic             err_clr
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_STEP, ST_CHECK} state_e;

  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_UP   = 2'b10;
  localparam logic [1:0] OP_DOWN = 2'b11;

  state_e             state_q;
  logic               up_q;
  logic [STEP_W-1:0]  remaining_q;
  logic [WIDTH-1:0]   data_q;
  logic [WIDTH-1:0]   expected_q;
  logic [WIDTH-1:0]   expected_d;
  logic               mismatch_q;
  logic               done_q;
  logic               accept;
  logic               check_fail;
  logic [STEP_W-1:0]  step_arg;

  function automatic logic [WIDTH-1:0] step_count(input logic [WIDTH-1:0] v, input logic up);
    return up ? v + WIDTH'(1) : v - WIDTH'(1);
  endfunction

  assign accept     = cmd_valid && (state_q == ST_IDLE);
  assign check_fail = (state_q == ST_CHECK) && (ctr_count != expected_q);
  assign step_arg   = cmd_arg[STEP_W-1:0];

  always_comb begin
    expected_d = expected_q;
    case (state_q)
      ST_LOAD:  expected_d = data_q;
      ST_STEP:  expected_d = step_count(expected_q, up_q);
`ifdef CTR_SEQ_RESYNC_EN
      ST_CHECK: if (check_fail) expected_d = ctr_count;
`endif
      default:  expected_d = expected_q;
    endcase
  end

  // Load value is only observed while in ST_LOAD, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) data_q <= cmd_arg[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      up_q        <= 1'b0;
      remaining_q <= '0;
      expected_q  <= '0;
      mismatch_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      expected_q <= expected_d;
      if (check_fail)   mismatch_q <= 1'b1;
      else if (err_clr) mismatch_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            up_q <= (cmd_op == OP_UP);
            if (cmd_op == OP_LOAD) begin
              state_q <= ST_LOAD;
            end else if ((cmd_op == OP_UP || cmd_op == OP_DOWN) && step_arg != '0) begin
              state_q     <= ST_STEP;
              remaining_q <= step_arg;
            end else begin
              state_q <= ST_CHECK;
            end
          end
        end
        ST_LOAD: state_q <= ST_CHECK;
        ST_STEP: begin
          remaining_q <= remaining_q - STEP_W'(1);
          if (remaining_q == STEP_W'(1)) state_q <= ST_CHECK;
        end
        ST_CHECK: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Counter controls decode from state alone, so an async reset silences them at once.
  assign ctr_preload = (state_q == ST_LOAD);
  assign ctr_enable  = (state_q == ST_STEP);
  assign ctr_up_down = (state_q == ST_STEP) && up_q;
  assign ctr_data    = (state_q == ST_LOAD) ? data_q : '0;
  assign cmd_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign expected    = expected_q;
  assign mismatch    = mismatch_q;

endmodule

// File: tb/tb_counter_cmd_seq.sv
// Directed bench for counter_cmd_seq driving a behavioural 8-bit counter with an enable-fault hook.
module tb_counter_cmd_seq;
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_arg = 8'h00;
  logic       ctr_enable, ctr_up_down, ctr_preload;
  logic [7:0] ctr_data, ctr_count, expected;
  logic       busy, done, mismatch;
  logic       err_clr = 1'b0;
  logic       fault = 1'b0;
  logic [7:0] cnt;
  int         errors = 0;
  int         checks = 0;

`ifdef CTR_SEQ_RESYNC_EN
  localparam logic [7:0] EXP_FAULT1 = 8'h10;
  localparam logic [7:0] EXP_FAULT2 = 8'h10;
`else
  localparam logic [7:0] EXP_FAULT1 = 8'h12;
  localparam logic [7:0] EXP_FAULT2 = 8'h13;
`endif

  always #5 clk = ~clk;

  counter_cmd_seq #(.WIDTH(8), .STEP_W(8)) dut (
    .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .ctr_enable(ctr_enable), .ctr_up_down(ctr_up_down),
    .ctr_preload(ctr_preload), .ctr_data(ctr_data), .ctr_count(ctr_count), .busy(busy),
    .done(done), .expected(expected), .mismatch(mismatch), .err_clr(err_clr)
  );

  always @(posedge clk or negedge resetn) begin
    if (!resetn)                   cnt <= 8'h00;
    else if (ctr_preload)          cnt <= ctr_data;
    else if (ctr_enable && !fault) cnt <= ctr_up_down ? cnt + 8'h01 : cnt - 8'h01;
  end
  assign ctr_count = cnt;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Issues one command and follows it until done, tallying counter-pin activity per cycle.
  task automatic run_cmd(input logic [1:0] op, input logic [7:0] arg, output int lat,
                         output int pre_n, output int en_n, output int dir_bad, output int oth_bad);
    cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
    tick();
    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_arg = 8'h00;
    lat = 1; pre_n = 0; en_n = 0; dir_bad = 0; oth_bad = 0;
    while (!done && lat < 300) begin
      if (ctr_preload) begin pre_n++; if (ctr_data !== arg) oth_bad++; end
      else if (ctr_data !== 8'h00) oth_bad++;
      if (ctr_enable) begin en_n++; if (ctr_up_down !== (op == 2'b10)) dir_bad++; end
      if (ctr_enable && ctr_preload) oth_bad++;
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #12;
    resetn = 1'b1;
    tick();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", cmd_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (ctr_enable !== 1'b0 || ctr_preload !== 1'b0) begin errors++; $display("FAIL rst_ctl got en=%b pre=%b want 0", ctr_enable, ctr_preload); end
    checks++; if (ctr_data !== 8'h00) begin errors++; $display("FAIL rst_data got %h want 00", ctr_data); end
    checks++; if (expected !== 8'h00) begin errors++; $display("FAIL rst_expected got %h want 00", expected); end
    checks++; if (mismatch !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_flags got mm=%b done=%b want 0", mismatch, done); end
  endtask

  task automatic test_load();
    int lat, pn, en, db, ob;
    run_cmd(2'b01, 8'hA5, lat, pn, en, db, ob);
    checks++; if (lat !== 3) begin errors++; $display("FAIL load_latency got %0d want 3", lat); end
    checks++; if (pn !== 1 || en !== 0 || ob !== 0) begin errors++; $display("FAIL load_pins got pre=%0d en=%0d bad=%0d want 1 0 0", pn, en, ob); end
    checks++; if (expected !== 8'hA5 || cnt !== 8'hA5) begin errors++; $display("FAIL load_value got exp=%h cnt=%h want a5", expected, cnt); end
    checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL load_mismatch got %b want 0", mismatch); end
  endtask

  task automatic test_step();
    int lat, pn, en, db, ob;
    run_cmd(2'b01, 8'hFE, lat, pn, en, db, ob);
    run_cmd(2'b10, 8'd3, lat, pn, en, db, ob);
    checks++; if (lat !== 5) begin errors++; $display("FAIL up3_latency got %0d want 5", lat); end
    checks++; if (en !== 3 || db !== 0 || pn !== 0 || ob !== 0) begin errors++; $display("FAIL up3_pins got en=%0d dir=%0d pre=%0d bad=%0d want 3 0 0 0", en, db, pn, ob); end
    checks++; if (expected !== 8'h01 || mismatch !== 1'b0) begin errors++; $display("FAIL up3_wrap got exp=%h mm=%b want 01 0", expected, mismatch); end
    run_cmd(2'b11, 8'd2, lat, pn, en, db, ob);
    checks++; if (lat !== 4 || en !== 2 || db !== 0) begin errors++; $display("FAIL down2_pins got lat=%0d en=%0d dir=%0d want 4 2 0", lat, en, db); end
    checks++; if (expected !== 8'hFF || mismatch !== 1'b0) begin errors++; $display("FAIL down2_wrap got exp=%h mm=%b want ff 0", expected, mismatch); end
  endtask

  task automatic test_nop();
    int lat, pn, en, db, ob;
    run_cmd(2'b00, 8'h37, lat, pn, en, db, ob);
    checks++; if (lat !== 2 || pn !== 0 || en !== 0 || ob !== 0) begin errors++; $display("FAIL nop got lat=%0d pre=%0d en=%0d bad=%0d want 2 0 0 0", lat, pn, en, ob); end
    checks++; if (expected !== 8'hFF) begin errors++; $display("FAIL nop_expected got %h want ff", expected); end
    run_cmd(2'b11, 8'h00, lat, pn, en, db, ob);
    checks++; if (lat !== 2 || pn !== 0 || en !== 0 || ob !== 0) begin errors++; $display("FAIL down0 got lat=%0d pre=%0d en=%0d bad=%0d want 2 0 0 0", lat, pn, en, ob); end
    checks++; if (expected !== 8'hFF || mismatch !== 1'b0) begin errors++; $display("FAIL down0_state got exp=%h mm=%b want ff 0", expected, mismatch); end
  endtask

  task automatic test_back_to_back();
    int lat, pn, en, db, ob;
    run_cmd(2'b10, 8'd1, lat, pn, en, db, ob);
    checks++; if (done !== 1'b1 || cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got done=%b ready=%b want 1 1", done, cmd_ready); end
    checks++; if (expected !== 8'h00) begin errors++; $display("FAIL b2b_first got %h want 00", expected); end
    run_cmd(2'b11, 8'd1, lat, pn, en, db, ob);
    checks++; if (lat !== 3 || en !== 1 || db !== 0) begin errors++; $display("FAIL b2b_second got lat=%0d en=%0d dir=%0d want 3 1 0", lat, en, db); end
    checks++; if (expected !== 8'hFF || mismatch !== 1'b0) begin errors++; $display("FAIL b2b_final got exp=%h mm=%b want ff 0", expected, mismatch); end
  endtask

  task automatic test_fault();
    int lat, pn, en, db, ob;
    run_cmd(2'b01, 8'h10, lat, pn, en, db, ob);
    fault = 1'b1;
    run_cmd(2'b10, 8'd2, lat, pn, en, db, ob);
    fault = 1'b0;
    checks++; if (mismatch !== 1'b1) begin errors++; $display("FAIL fault_flag got %b want 1", mismatch); end
    checks++; if (expected !== EXP_FAULT1 || cnt !== 8'h10) begin errors++; $display("FAIL fault_expected got exp=%h cnt=%h want %h 10", expected, cnt, EXP_FAULT1); end
    tick();
    checks++; if (mismatch !== 1'b1) begin errors++; $display("FAIL fault_sticky got %b want 1", mismatch); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL err_clr got %b want 0", mismatch); end
    err_clr = 1'b1; fault = 1'b1;
    run_cmd(2'b10, 8'd1, lat, pn, en, db, ob);
    err_clr = 1'b0; fault = 1'b0;
    checks++; if (mismatch !== 1'b1) begin errors++; $display("FAIL set_wins got %b want 1", mismatch); end
    checks++; if (expected !== EXP_FAULT2) begin errors++; $display("FAIL fault2_expected got %h want %h", expected, EXP_FAULT2); end
    run_cmd(2'b01, 8'h00, lat, pn, en, db, ob);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++; if (mismatch !== 1'b0 || expected !== 8'h00) begin errors++; $display("FAIL recover got mm=%b exp=%h want 0 00", mismatch, expected); end
  endtask

  task automatic test_reset_mid();
    int seen_done;
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_arg = 8'd5;
    tick();
    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_arg = 8'h00;
    tick();
    checks++; if (ctr_enable !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL mid_active got en=%b busy=%b want 1 1", ctr_enable, busy); end
    resetn = 1'b0;
    #1;
    checks++; if (ctr_enable !== 1'b0 || ctr_up_down !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_async got en=%b ud=%b busy=%b want 0 0 0", ctr_enable, ctr_up_down, busy); end
    #2;
    resetn = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) seen_done++;
    end
    checks++; if (seen_done !== 0) begin errors++; $display("FAIL mid_no_done got %0d pulses want 0", seen_done); end
    checks++; if (cmd_ready !== 1'b1 || expected !== 8'h00 || cnt !== 8'h00) begin errors++; $display("FAIL mid_after got ready=%b exp=%h cnt=%h want 1 00 00", cmd_ready, expected, cnt); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_step();
    test_nop();
    test_back_to_back();
    test_fault();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule
